// File: rtl/adpll_mon_pkg.sv
// adpll_mon_pkg -- shared definitions for the ADPLL lock monitor.
//   FSM state encoding, FREQ_ERR width, ratio decode (M==0 means 8) and
//   the 5-bit signed saturation helper.
// Optional feature macro used elsewhere in this slice: ADPLL_MON_PHASE_EN.
package adpll_mon_pkg;

    localparam int FERR_W = 5;

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    // M is a 3-bit ratio; the all-zero code stands for 8.
    function automatic logic [3:0] ratio_dec(input logic [2:0] m);
        return (m == 3'd0) ? 4'd8 : {1'b0, m};
    endfunction

    // Clamp a signed difference into the 5-bit two's complement range.
    function automatic logic [FERR_W-1:0] sat5(input int v);
        if (v > 15)  return 5'h0F;
        if (v < -16) return 5'h10;
        return v[FERR_W-1:0];
    endfunction

endpackage

// File: rtl/adpll_lock_monitor_if.sv
// adpll_lock_monitor_if -- signal bundle between the ADPLL side and the monitor.
//   master : drives REF_IN, FB_IN, M, LOCK, POLARITY; observes monitor outputs.
//   slave  : the monitor; outputs MON_LOCK, FREQ_ERR, MEAS_VLD, MISMATCH, REF_LOST.
//   With ADPLL_MON_PHASE_EN defined, PHASE_CNT[7:0] and POL_ERR are added.
interface adpll_lock_monitor_if;
    import adpll_mon_pkg::*;

    logic              REF_IN;
    logic              FB_IN;
    logic [2:0]        M;
    logic              LOCK;
    logic              POLARITY;
    logic              MON_LOCK;
    logic [FERR_W-1:0] FREQ_ERR;
    logic              MEAS_VLD;
    logic              MISMATCH;
    logic              REF_LOST;
`ifdef ADPLL_MON_PHASE_EN
    logic [7:0]        PHASE_CNT;
    logic              POL_ERR;
`endif

    modport master (
        output REF_IN, FB_IN, M, LOCK, POLARITY,
        input  MON_LOCK, FREQ_ERR, MEAS_VLD, MISMATCH, REF_LOST
`ifdef ADPLL_MON_PHASE_EN
        , input PHASE_CNT, POL_ERR
`endif
    );

    modport slave (
        input  REF_IN, FB_IN, M, LOCK, POLARITY,
        output MON_LOCK, FREQ_ERR, MEAS_VLD, MISMATCH, REF_LOST
`ifdef ADPLL_MON_PHASE_EN
        , output PHASE_CNT, POL_ERR
`endif
    );

endinterface

// File: rtl/adpll_edge_sync.sv
// adpll_edge_sync -- STAGES-deep synchroniser plus registered rising-edge pulse.
//   clk_i/rst_i : sample clock, async active-high reset
//   d_i         : asynchronous input
//   rise_o      : one-cycle pulse, STAGES+1 cycles after the pin rises
module adpll_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/adpll_lock_monitor.sv
// adpll_lock_monitor -- independent frequency/lock checker beside the ADPLL.
//   SMP_CLK : fast sample clock (>= 4x OUT_CLK)
//   RESET   : asynchronous, active-high
//   mon     : slave side of adpll_lock_monitor_if (REF/FB pins, M, LOCK,
//             POLARITY in; MON_LOCK, FREQ_ERR, MEAS_VLD, MISMATCH, REF_LOST out)
// Counts FB rises per REF period, reports (count - ratio), runs a lock FSM
// and flags sustained disagreement with the ADPLL's own LOCK.
// Optional: ADPLL_MON_PHASE_EN adds PHASE_CNT / POL_ERR phase checking.
module adpll_lock_monitor
    import adpll_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2,
    parameter int TOL         = 0,
    parameter int TIMEOUT     = 1023
) (
    input  logic            SMP_CLK,
    input  logic            RESET,
    adpll_lock_monitor_if.slave mon
);
    logic ref_rise, fb_rise;

    adpll_edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
        .clk_i(SMP_CLK), .rst_i(RESET), .d_i(mon.REF_IN), .rise_o(ref_rise));
    adpll_edge_sync #(.STAGES(SYNC_STAGES)) u_fb_sync (
        .clk_i(SMP_CLK), .rst_i(RESET), .d_i(mon.FB_IN), .rise_o(fb_rise));

    logic [1:0]        state_q, state_d;
    logic [7:0]        good_q, good_d, bad_q, bad_d;
    logic [3:0]        cnt_q, ratio_q;
    logic [2:0]        m_q;
    logic              open_q, vld_q, mchg_q;
    logic [FERR_W-1:0] ferr_q;
    logic [9:0]        tmo_q;
    logic [1:0]        mm_q;
    logic              mism_q;
    logic              timeout, mon_lock, good;
    int                ferr_s;

    assign timeout  = (tmo_q == 10'(TIMEOUT));
    assign mon_lock = (state_q == ST_LOCKED);

    always_comb begin
        ferr_s = int'($signed(ferr_q));
        good   = (ferr_s <= TOL) && (ferr_s >= -TOL);
    end

    // Period measurement. open_q marks that a REF rise has started a period
    // we are allowed to report; it is dropped by reset and by REF loss.
    always_ff @(posedge SMP_CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= '0;
            ratio_q <= '0;
            m_q     <= '0;
            open_q  <= 1'b0;
            vld_q   <= 1'b0;
            mchg_q  <= 1'b0;
            ferr_q  <= '0;
            tmo_q   <= '0;
        end else if (ref_rise) begin
            // A coincident FB rise belongs to the period that opens here.
            cnt_q   <= fb_rise ? 4'd1 : 4'd0;
            ratio_q <= ratio_dec(mon.M);
            m_q     <= mon.M;
            open_q  <= 1'b1;
            vld_q   <= open_q;
            mchg_q  <= open_q && (mon.M != m_q);
            if (open_q)
                ferr_q <= sat5(int'(cnt_q) - int'(ratio_q));
            tmo_q   <= '0;
        end else begin
            vld_q <= 1'b0;
            if (fb_rise && cnt_q != 4'hF)
                cnt_q <= cnt_q + 4'd1;
            if (tmo_q != 10'h3FF)
                tmo_q <= tmo_q + 10'd1;
            if (timeout)
                open_q <= 1'b0;
        end
    end

    // Lock FSM, advanced by the registered measurement strobe.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (ref_rise) begin
            if (state_q == ST_LOST)
                state_d = ST_ACQUIRE;
        end else if (timeout) begin
            state_d = ST_LOST;
            good_d  = '0;
            bad_d   = '0;
        end
        if (vld_q) begin
            if (mchg_q) begin
                state_d = ST_ACQUIRE;
                good_d  = '0;
                bad_d   = '0;
            end else begin
                case (state_q)
                    ST_ACQUIRE, ST_TRACK: begin
                        if (good) begin
                            good_d  = good_q + 8'd1;
                            state_d = (good_d >= 8'(LOCK_CNT)) ? ST_LOCKED : ST_TRACK;
                        end else begin
                            state_d = ST_ACQUIRE;
                            good_d  = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (good) begin
                            bad_d = '0;
                        end else begin
                            bad_d = bad_q + 8'd1;
                            if (bad_d >= 8'(UNLOCK_CNT)) begin
                                state_d = ST_ACQUIRE;
                                good_d  = '0;
                                bad_d   = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge SMP_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_ACQUIRE;
            good_q  <= '0;
            bad_q   <= '0;
            mm_q    <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            // Compare the verdict held during the period against the ADPLL's LOCK.
            if (vld_q) begin
                if (mon_lock != mon.LOCK) begin
                    if (mm_q != 2'd3)
                        mm_q <= mm_q + 2'd1;
                    mism_q <= (mm_q >= 2'd1);
                end else begin
                    mm_q   <= '0;
                    mism_q <= 1'b0;
                end
            end
        end
    end

    assign mon.MON_LOCK = mon_lock;
    assign mon.FREQ_ERR = ferr_q;
    assign mon.MEAS_VLD = vld_q;
    assign mon.MISMATCH = mism_q;
    assign mon.REF_LOST = (state_q == ST_LOST);

`ifdef ADPLL_MON_PHASE_EN
    logic [7:0] ph_run_q, ph_cap_q, phase_q;
    logic       ph_done_q, pol_q;
    logic [9:0] per_run_q, per_cap_q;

    // ph_run_q counts cycles from the REF rise until the first FB rise;
    // per_run_q measures the full period so POL_ERR can use half of it.
    always_ff @(posedge SMP_CLK or posedge RESET) begin
        if (RESET) begin
            ph_run_q  <= '0;
            ph_cap_q  <= '0;
            phase_q   <= '0;
            ph_done_q <= 1'b0;
            pol_q     <= 1'b0;
            per_run_q <= '0;
            per_cap_q <= '0;
        end else begin
            if (ref_rise) begin
                ph_cap_q  <= ph_run_q;
                per_cap_q <= per_run_q;
                ph_run_q  <= fb_rise ? 8'd0 : 8'd1;
                ph_done_q <= fb_rise;
                per_run_q <= 10'd1;
            end else begin
                if (!ph_done_q) begin
                    if (fb_rise)
                        ph_done_q <= 1'b1;
                    else if (ph_run_q != 8'hFF)
                        ph_run_q <= ph_run_q + 8'd1;
                end
                if (per_run_q != 10'h3FF)
                    per_run_q <= per_run_q + 10'd1;
            end
            if (vld_q) begin
                phase_q <= ph_cap_q;
                pol_q   <= mon_lock &&
                           (mon.POLARITY != ({2'b00, ph_cap_q} <= (per_cap_q >> 1)));
            end
        end
    end

    assign mon.PHASE_CNT = phase_q;
    assign mon.POL_ERR   = pol_q;
`else
    logic unused_pol;
    assign unused_pol = mon.POLARITY;
`endif

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// tb_adpll_lock_monitor -- randomized + directed bench for adpll_lock_monitor.
// REF periods are 64 SMP_CLK cycles with N evenly spaced FB pulses; a
// period-level reference model predicts FREQ_ERR, lock verdict and MISMATCH.
module tb_adpll_lock_monitor;
    localparam int TOL = 0;
    localparam int LOCK_CNT = 4;
    localparam int UNLOCK_CNT = 2;

    logic gclk = 1'b0;
    logic rst  = 1'b1;
    always #5 gclk = ~gclk;

    adpll_lock_monitor_if mon_if();

    adpll_lock_monitor dut (
        .SMP_CLK (gclk),
        .RESET   (rst),
        .mon     (mon_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    int vld_seen = 0;
    int vld_snap = 0;

    always @(posedge gclk) if (mon_if.MEAS_VLD === 1'b1) vld_seen <= vld_seen + 1;

    // model state (period level)
    int m_open = 0, m_cnt_n = 0, m_ratio = 0, m_ferr = 0, cur_m = 0;
    int m_locked = 0, m_run = 0, m_bad = 0, m_dc = 0, m_mism = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_locked = 0; m_run = 0; m_bad = 0;
        m_dc = 0; m_mism = 0; m_ferr = 0;
    endtask

    // Close the open period at a REF rise that carries LOCK=lockval, M=mval.
    task automatic model_close(input int lockval, input int mval);
        int cnt, err, is_good;
        cnt = (m_cnt_n > 15) ? 15 : m_cnt_n;
        err = cnt - m_ratio;
        if (err > 15) err = 15;
        if (err < -16) err = -16;
        m_ferr = err;
        is_good = (err <= TOL && err >= -TOL);
        if (m_locked != lockval) begin
            m_dc = (m_dc < 3) ? m_dc + 1 : 3;
            m_mism = (m_dc >= 2);
        end else begin
            m_dc = 0; m_mism = 0;
        end
        if (mval != cur_m) begin
            m_locked = 0; m_run = 0; m_bad = 0;
        end else if (!m_locked) begin
            if (is_good) begin
                m_run++;
                if (m_run >= LOCK_CNT) begin m_locked = 1; m_bad = 0; end
            end else m_run = 0;
        end else begin
            if (is_good) m_bad = 0;
            else begin
                m_bad++;
                if (m_bad >= UNLOCK_CNT) begin m_locked = 0; m_run = 0; m_bad = 0; end
            end
        end
    endtask

    task automatic check_outs(input int exp_vld);
        logic [4:0] fe;
        fe = m_ferr[4:0];
        chk("meas_vld_count", 32'(vld_seen - vld_snap), 32'(exp_vld));
        vld_snap = vld_seen;
        chk("freq_err", 32'(mon_if.FREQ_ERR), 32'(fe));
        chk("mon_lock", 32'(mon_if.MON_LOCK), 32'(m_locked));
        chk("mismatch", 32'(mon_if.MISMATCH), 32'(m_mism));
        chk("ref_lost", 32'(mon_if.REF_LOST), 32'd0);
    endtask

    // One 64-cycle REF period with n FB rises; optional reset at offset 40.
    task automatic run_period(input int n, input int mval, input int lockval, input int rst_mid);
        int step, st, exp_vld;
        logic fb;
        exp_vld = m_open;
        if (m_open) model_close(lockval, mval);
        m_open = 1; m_cnt_n = n; m_ratio = (mval == 0) ? 8 : mval; cur_m = mval;
        st = int'($urandom_range(0, 1));
        step = (n > 0) ? 64 / n : 64;
        for (int o = 0; o < 64; o++) begin
            @(negedge gclk);
            mon_if.REF_IN = (o < 32);
            mon_if.M = 3'(mval);
            mon_if.LOCK = (lockval != 0);
            fb = 1'b0;
            for (int k = 0; k < n; k++)
                if (o == st + k * step || o == st + k * step + 1) fb = 1'b1;
            mon_if.FB_IN = fb;
            if (o == 12) check_outs(exp_vld);
            if (rst_mid != 0 && o == 40) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                chk("rst_mon_lock", 32'(mon_if.MON_LOCK), 32'd0);
                chk("rst_freq_err", 32'(mon_if.FREQ_ERR), 32'd0);
                chk("rst_meas_vld", 32'(mon_if.MEAS_VLD), 32'd0);
                chk("rst_mismatch", 32'(mon_if.MISMATCH), 32'd0);
                chk("rst_ref_lost", 32'(mon_if.REF_LOST), 32'd0);
            end
            if (rst_mid != 0 && o == 44) rst = 1'b0;
        end
    endtask

    task automatic idle_ref(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge gclk);
            mon_if.REF_IN = 1'b0;
            mon_if.FB_IN  = 1'b0;
            if (c == 900) chk("ref_lost_early", 32'(mon_if.REF_LOST), 32'd0);
        end
        m_open = 0; m_locked = 0; m_run = 0; m_bad = 0;
        chk("ref_lost", 32'(mon_if.REF_LOST), 32'd1);
        chk("lost_mon_lock", 32'(mon_if.MON_LOCK), 32'd0);
        chk("lost_meas_vld_count", 32'(vld_seen - vld_snap), 32'd0);
        vld_snap = vld_seen;
    endtask

    initial begin
        int mv, n, r;
        mon_if.REF_IN = 1'b0; mon_if.FB_IN = 1'b0; mon_if.M = 3'd4;
        mon_if.LOCK = 1'b0; mon_if.POLARITY = 1'b0;
        repeat (4) @(negedge gclk);
        chk("reset_mon_lock", 32'(mon_if.MON_LOCK), 32'd0);
        chk("reset_freq_err", 32'(mon_if.FREQ_ERR), 32'd0);
        chk("reset_meas_vld", 32'(mon_if.MEAS_VLD), 32'd0);
        chk("reset_mismatch", 32'(mon_if.MISMATCH), 32'd0);
        chk("reset_ref_lost", 32'(mon_if.REF_LOST), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge gclk);

        // lock at M=4, then two +1 periods to unlock
        for (int i = 0; i < 6; i++) run_period(4, 4, (i >= 5) ? 1 : 0, 0);
        run_period(5, 4, 1, 0);
        run_period(5, 4, 1, 0);
        run_period(4, 4, 1, 0);
        run_period(4, 4, 0, 0);
        // M=0 means ratio 8; then one period short by one
        for (int i = 0; i < 7; i++) run_period(8, 0, 0, 0);
        run_period(7, 0, 1, 0);
        run_period(8, 0, 1, 0);
        // monitor locked while ADPLL claims unlock, then agreement
        for (int i = 0; i < 6; i++) run_period(4, 4, 0, 0);
        for (int i = 0; i < 3; i++) run_period(4, 4, 0, 0);
        run_period(4, 4, 1, 0);
        run_period(4, 4, 1, 0);
        // FB counter saturation at ratio 1
        run_period(16, 1, 0, 0);
        run_period(16, 1, 0, 0);
        run_period(1, 1, 0, 0);
        // REF loss and restart
        idle_ref(1100);
        for (int i = 0; i < 6; i++) run_period(3, 3, 0, 0);
        // reset mid-period while locked
        run_period(3, 3, 1, 1);
        for (int i = 0; i < 3; i++) run_period(3, 3, 0, 0);

        // randomized periods
        mv = 5;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) mv = int'($urandom_range(0, 7));
            r = (mv == 0) ? 8 : mv;
            n = r;
            if ($urandom_range(0, 3) == 0) n = r + int'($urandom_range(0, 2)) - 1;
            run_period(n, mv, int'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
